mem_0_stage: RTL and testbench

// - First memory pipeline stage. Feeds the m0_m1_* bundle into the Mem_1 data-RAM stage.
// - Accepts execute results over a valid/ready handshake and computes the effective address.
// - Buffers ops in a DEPTH-entry FIFO.
// - Holds the pipeline, emitting bubbles, while the data RAM is being loaded (mem_ram_load).

---
 rtl/mem_0_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_0_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_0_stage.sv
// mem_0_stage: first memory pipeline stage, feeding the Mem_1 data-RAM stage.
//
// Accepts execute results, computes the effective byte address (base+offset,
// wrapping mod 2^32), queues the ops in a DEPTH-entry FIFO and presents one
// registered op per cycle on the m0_m1_* bundle. While the data RAM is being
// loaded (mem_ram_load) the FIFO head is frozen and bubbles are emitted.
//
// Handshake: an op transfers on a rising clock edge where ex_m0_valid and
// m0_ex_ready are both 1. m0_ex_ready is combinational (count<DEPTH && !flush)
// and does not depend on ex_m0_valid; the producer holds its op stable until
// the transfer edge.
//
// Ports:
//   clock, reset (async, active-low)
//   mem_ram_load        hold: FIFO frozen, output bubbles, pushes still allowed
//   ex_m0_flush         discard all buffered ops (wins over push and pop)
//   ex_m0_valid/m0_ex_ready, ex_m0_readmem/writemem/base/offset/regb/
//   regdest/writereg    incoming op
//   m0_m1_oper/readmem/writemem/data_addr/regb/regdest/writereg  outgoing op
//   m0_hold_count       saturating count of hold cycles with FIFO non-empty
//   m0_exc_misaligned   only with MEM0_ALIGN_TRAP_EN defined: pulses for one
//                       cycle when a misaligned memory op is dropped
//
// Build option: MEM0_ALIGN_TRAP_EN turns misaligned memory ops into bubbles
// and adds m0_exc_misaligned.

module mem_0_stage #(
    parameter int DEPTH     = 2,
    parameter int RAM_WORDS = 128,
    parameter int REG_W     = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_ram_load,
    input  logic             ex_m0_flush,
    input  logic             ex_m0_valid,
    output logic             m0_ex_ready,
    input  logic             ex_m0_readmem,
    input  logic             ex_m0_writemem,
    input  logic [31:0]      ex_m0_base,
    input  logic [31:0]      ex_m0_offset,
    input  logic [31:0]      ex_m0_regb,
    input  logic [REG_W-1:0] ex_m0_regdest,
    input  logic             ex_m0_writereg,
    output logic             m0_m1_oper,
    output logic             m0_m1_readmem,
    output logic             m0_m1_writemem,
    output logic [31:0]      m0_m1_data_addr,
    output logic [31:0]      m0_m1_regb,
    output logic [REG_W-1:0] m0_m1_regdest,
    output logic             m0_m1_writereg,
    output logic [15:0]      m0_hold_count
`ifdef MEM0_ALIGN_TRAP_EN
    ,
    output logic             m0_exc_misaligned
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Elaboration-time parameter sanity: pointer wrap relies on a power-of-2
    // depth, and Mem_1 needs a non-empty word range.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RAM_WORDS < 1)) begin : g_bad_param
        $error("mem_0_stage: DEPTH must be a power of 2 >= 2 and RAM_WORDS >= 1");
    end

    typedef struct packed {
        logic             readmem;
        logic             writemem;
        logic [31:0]      addr;
        logic [31:0]      regb;
        logic [REG_W-1:0] regdest;
        logic             writereg;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    entry_t push_entry;
    entry_t head;
    logic   push;
    logic   pop;
    logic   trap;
    logic   emit_op;

    assign m0_ex_ready = (count < CNT_W'(DEPTH)) && !ex_m0_flush;
    assign push        = ex_m0_valid && m0_ex_ready;
    // Flush and hold both suppress the pop; an empty FIFO has nothing to pop.
    assign pop         = !ex_m0_flush && !mem_ram_load && (count != '0);

    always_comb begin
        push_entry          = '0;
        push_entry.readmem  = ex_m0_readmem;
        // A load+store request is treated as a load only.
        push_entry.writemem = ex_m0_writemem & ~ex_m0_readmem;
        push_entry.addr     = ex_m0_base + ex_m0_offset;
        push_entry.regb     = ex_m0_regb;
        push_entry.regdest  = ex_m0_regdest;
        push_entry.writereg = ex_m0_writereg;
    end

    always_comb begin
        head = fifo_q[rd_ptr];
        trap = 1'b0;
`ifdef MEM0_ALIGN_TRAP_EN
        trap = pop && (head.readmem || head.writemem) && (head.addr[1:0] != 2'b00);
`endif
        emit_op = pop && !trap;
    end

    // Storage carries no reset: validity is tracked entirely by count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (ex_m0_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Uses the pre-edge count, so a flush during hold still counts that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0_hold_count <= '0;
        end else if (mem_ram_load && (count != '0) && (m0_hold_count != 16'hFFFF)) begin
            m0_hold_count <= m0_hold_count + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0_m1_oper      <= 1'b0;
            m0_m1_readmem   <= 1'b0;
            m0_m1_writemem  <= 1'b0;
            m0_m1_data_addr <= '0;
            m0_m1_regb      <= '0;
            m0_m1_regdest   <= '0;
            m0_m1_writereg  <= 1'b0;
        end else if (emit_op) begin
            m0_m1_oper      <= 1'b1;
            m0_m1_readmem   <= head.readmem;
            m0_m1_writemem  <= head.writemem;
            m0_m1_data_addr <= head.addr;
            m0_m1_regb      <= head.regb;
            m0_m1_regdest   <= head.regdest;
            m0_m1_writereg  <= head.writereg;
        end else begin
            m0_m1_oper      <= 1'b0;
            m0_m1_readmem   <= 1'b0;
            m0_m1_writemem  <= 1'b0;
            m0_m1_data_addr <= '0;
            m0_m1_regb      <= '0;
            m0_m1_regdest   <= '0;
            m0_m1_writereg  <= 1'b0;
        end
    end

`ifdef MEM0_ALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0_exc_misaligned <= 1'b0;
        end else begin
            m0_exc_misaligned <= trap;
        end
    end
`endif

endmodule

// File: tb/tb_mem_0_stage.sv
// Directed, table-driven bench for mem_0_stage (DEPTH=2, REG_W=5).
// Output bundle is compared as {oper, readmem, writemem, addr, regb, regdest, writereg}.

module tb_mem_0_stage;

    localparam int BW = 73;

    logic        clock;
    logic        reset;
    logic        mem_ram_load;
    logic        ex_m0_flush;
    logic        ex_m0_valid;
    logic        m0_ex_ready;
    logic        ex_m0_readmem;
    logic        ex_m0_writemem;
    logic [31:0] ex_m0_base;
    logic [31:0] ex_m0_offset;
    logic [31:0] ex_m0_regb;
    logic [4:0]  ex_m0_regdest;
    logic        ex_m0_writereg;
    logic        m0_m1_oper;
    logic        m0_m1_readmem;
    logic        m0_m1_writemem;
    logic [31:0] m0_m1_data_addr;
    logic [31:0] m0_m1_regb;
    logic [4:0]  m0_m1_regdest;
    logic        m0_m1_writereg;
    logic [15:0] m0_hold_count;
`ifdef MEM0_ALIGN_TRAP_EN
    logic        m0_exc_misaligned;
`endif

    mem_0_stage #(.DEPTH(2), .RAM_WORDS(128), .REG_W(5)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_ram_load    (mem_ram_load),
        .ex_m0_flush     (ex_m0_flush),
        .ex_m0_valid     (ex_m0_valid),
        .m0_ex_ready     (m0_ex_ready),
        .ex_m0_readmem   (ex_m0_readmem),
        .ex_m0_writemem  (ex_m0_writemem),
        .ex_m0_base      (ex_m0_base),
        .ex_m0_offset    (ex_m0_offset),
        .ex_m0_regb      (ex_m0_regb),
        .ex_m0_regdest   (ex_m0_regdest),
        .ex_m0_writereg  (ex_m0_writereg),
        .m0_m1_oper      (m0_m1_oper),
        .m0_m1_readmem   (m0_m1_readmem),
        .m0_m1_writemem  (m0_m1_writemem),
        .m0_m1_data_addr (m0_m1_data_addr),
        .m0_m1_regb      (m0_m1_regb),
        .m0_m1_regdest   (m0_m1_regdest),
        .m0_m1_writereg  (m0_m1_writereg),
        .m0_hold_count   (m0_hold_count)
`ifdef MEM0_ALIGN_TRAP_EN
        ,
        .m0_exc_misaligned (m0_exc_misaligned)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0] exp_q[$];

    wire [BW-1:0] out_bundle = {m0_m1_oper, m0_m1_readmem, m0_m1_writemem, m0_m1_data_addr,
                                m0_m1_regb, m0_m1_regdest, m0_m1_writereg};
    localparam logic [BW-1:0] BUBBLE = '0;

    function automatic logic [BW-1:0] op_bundle(input logic rd, input logic wr,
                                                 input logic [31:0] addr, input logic [31:0] regb,
                                                 input logic [4:0] rdst, input logic wreg);
        return {1'b1, rd, wr, addr, regb, rdst, wreg};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name);
        logic [BW-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected queue empty, got %h", name, out_bundle);
        end else begin
            e = exp_q.pop_front();
            check(name, out_bundle, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [31:0] base,
                            input logic [31:0] off, input logic [31:0] regb,
                            input logic [4:0] rdst, input logic wreg);
        ex_m0_valid    = 1'b1;
        ex_m0_readmem  = rd;
        ex_m0_writemem = wr;
        ex_m0_base     = base;
        ex_m0_offset   = off;
        ex_m0_regb     = regb;
        ex_m0_regdest  = rdst;
        ex_m0_writereg = wreg;
        #1;
    endtask

    task automatic idle();
        ex_m0_valid    = 1'b0;
        ex_m0_readmem  = 1'b0;
        ex_m0_writemem = 1'b0;
        ex_m0_base     = '0;
        ex_m0_offset   = '0;
        ex_m0_regb     = '0;
        ex_m0_regdest  = '0;
        ex_m0_writereg = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        rd, wr;
        logic [31:0] base, off, regb;
        logic [4:0]  rdst;
        logic        wreg;
        logic        exp_rd, exp_wr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic apply_vec(input vec_t v);
        drive_op(v.rd, v.wr, v.base, v.off, v.regb, v.rdst, v.wreg);
        check({v.name, "_ready"}, BW'(m0_ex_ready), BW'(1'b1));
        step();
        idle();
        check({v.name, "_push_edge_bubble"}, out_bundle, BUBBLE);
        step();
        check({v.name, "_op"}, out_bundle,
              op_bundle(v.exp_rd, v.exp_wr, v.exp_addr, v.regb, v.rdst, v.wreg));
        step();
        check({v.name, "_after_bubble"}, out_bundle, BUBBLE);
    endtask

    initial begin
        vecs[0] = '{"load_108",   1'b1, 1'b0, 32'h0000_0100, 32'h0000_0008, 32'h0,         5'd3,  1'b1, 1'b1, 1'b0, 32'h0000_0108};
        vecs[1] = '{"store_neg",  1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0000_01FC};
        vecs[2] = '{"ld_st_norm", 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0004, 32'h1234_5678, 5'd7,  1'b1, 1'b1, 1'b0, 32'h0000_0044};
        vecs[3] = '{"addr_wrap",  1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0020, 32'hA5A5_5A5A, 5'd1,  1'b0, 1'b0, 1'b1, 32'h0000_0010};
        vecs[4] = '{"out_range",  1'b1, 1'b0, 32'h0000_1000, 32'h0000_0200, 32'h0,         5'd12, 1'b1, 1'b1, 1'b0, 32'h0000_1200};
        vecs[5] = '{"alu_op",     1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hCAFE_0001, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0000_000C};

        mem_ram_load = 1'b0;
        ex_m0_flush  = 1'b0;
        idle();
        reset = 1'b0;
        repeat (2) step();

        // Reset state
        check("reset_bundle", out_bundle, BUBBLE);
        check("reset_ready", BW'(m0_ex_ready), BW'(1'b1));
        check("reset_hold_count", BW'(m0_hold_count), BW'(16'd0));
`ifdef MEM0_ALIGN_TRAP_EN
        check("reset_exc", BW'(m0_exc_misaligned), BW'(1'b0));
`endif
        reset = 1'b1;
        step();

        // Table-driven single ops
        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Hold: three back-to-back pushes with Mem_1 held
        mem_ram_load = 1'b1;
        drive_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 5'd4, 1'b1);
        check("hold_ready_a", BW'(m0_ex_ready), BW'(1'b1));
        exp_q.push_back(op_bundle(1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1));
        step();
        check("hold_hc0", BW'(m0_hold_count), BW'(16'd0));
        drive_op(1'b0, 1'b1, 32'h20, 32'h4, 32'h1111_2222, 5'd5, 1'b0);
        check("hold_ready_b", BW'(m0_ex_ready), BW'(1'b1));
        exp_q.push_back(op_bundle(1'b0, 1'b1, 32'h24, 32'h1111_2222, 5'd5, 1'b0));
        step();
        check("hold_hc1", BW'(m0_hold_count), BW'(16'd1));
        check("hold_bubble1", out_bundle, BUBBLE);
        drive_op(1'b1, 1'b0, 32'h30, 32'h8, 32'h0, 5'd6, 1'b1);
        check("hold_ready_full", BW'(m0_ex_ready), BW'(1'b0));
        step();
        check("hold_hc2", BW'(m0_hold_count), BW'(16'd2));
        check("hold_bubble2", out_bundle, BUBBLE);
        check("hold_ready_full2", BW'(m0_ex_ready), BW'(1'b0));
        step();
        check("hold_hc3", BW'(m0_hold_count), BW'(16'd3));
        // Release: C stays valid and enters once a slot frees (push+pop, count stays 1)
        mem_ram_load = 1'b0;
        #1;
        check("rel_ready_still_full", BW'(m0_ex_ready), BW'(1'b0));
        step();
        check_pop("rel_op_a");
        check("rel_ready_free", BW'(m0_ex_ready), BW'(1'b1));
        exp_q.push_back(op_bundle(1'b1, 1'b0, 32'h38, 32'h0, 5'd6, 1'b1));
        step();
        idle();
        check_pop("rel_op_b");
        step();
        check_pop("rel_op_c");
        step();
        check("rel_bubble", out_bundle, BUBBLE);
        check("rel_hc_frozen", BW'(m0_hold_count), BW'(16'd3));
        check("rel_queue_empty", BW'(exp_q.size()), BW'(0));

        // Streaming: push every cycle while popping, ready stays high
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b0, 1'b1, 32'h400 + 32'(i * 16), 32'h4, 32'h100 + 32'(i), 5'(i + 8), 1'b0);
            check($sformatf("stream_ready_%0d", i), BW'(m0_ex_ready), BW'(1'b1));
            exp_q.push_back(op_bundle(1'b0, 1'b1, 32'h404 + 32'(i * 16), 32'h100 + 32'(i), 5'(i + 8), 1'b0));
            step();
            if (i > 0) check_pop($sformatf("stream_op_%0d", i - 1));
        end
        idle();
        step();
        check_pop("stream_op_3");
        step();
        check("stream_bubble", out_bundle, BUBBLE);

        // Flush with 2 entries buffered and valid high
        mem_ram_load = 1'b1;
        drive_op(1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 5'd9, 1'b1);
        step();
        drive_op(1'b1, 1'b0, 32'h504, 32'h0, 32'h0, 5'd10, 1'b1);
        step();
        ex_m0_flush = 1'b1;
        drive_op(1'b1, 1'b0, 32'h508, 32'h0, 32'h0, 5'd11, 1'b1);
        check("flush_ready_low", BW'(m0_ex_ready), BW'(1'b0));
        step();
        ex_m0_flush  = 1'b0;
        mem_ram_load = 1'b0;
        idle();
        #1;
        check("flush_bubble", out_bundle, BUBBLE);
        check("flush_ready_after", BW'(m0_ex_ready), BW'(1'b1));
        step();
        check("flush_empty1", out_bundle, BUBBLE);
        step();
        check("flush_empty2", out_bundle, BUBBLE);

        // Async reset mid-burst
        drive_op(1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 5'd13, 1'b1);
        step();
        drive_op(1'b1, 1'b0, 32'h604, 32'h0, 32'h0, 5'd14, 1'b1);
        step();
        check("burst_op_first", out_bundle, op_bundle(1'b1, 1'b0, 32'h600, 32'h0, 5'd13, 1'b1));
        idle();
        reset = 1'b0;
        #1;
        check("async_reset_bundle", out_bundle, BUBBLE);
        check("async_reset_ready", BW'(m0_ex_ready), BW'(1'b1));
        #1;
        reset = 1'b1;
        step();
        check("post_reset_empty", out_bundle, BUBBLE);
        apply_vec(vecs[0]);

`ifdef MEM0_ALIGN_TRAP_EN
        drive_op(1'b0, 1'b1, 32'h100, 32'h2, 32'h77, 5'd0, 1'b0);
        step();
        idle();
        step();
        check("mis_bubble", out_bundle, BUBBLE);
        check("mis_exc", BW'(m0_exc_misaligned), BW'(1'b1));
        step();
        check("mis_exc_pulse", BW'(m0_exc_misaligned), BW'(1'b0));
        drive_op(1'b0, 1'b1, 32'h100, 32'h4, 32'h77, 5'd0, 1'b0);
        step();
        idle();
        step();
        check("aligned_store", out_bundle, op_bundle(1'b0, 1'b1, 32'h104, 32'h77, 5'd0, 1'b0));
        check("aligned_no_exc", BW'(m0_exc_misaligned), BW'(1'b0));
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
